// File: rtl/decode_sb_stage.sv
// Decode/issue stage: 2R/1W register file, per-register pending-write scoreboard,
// and a one-entry output register with a valid/ready handshake toward execute.
module decode_sb_stage #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int CNT_W     = 2,
  parameter int PAYLOAD_W = 32,
  localparam int RIDX     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 sb_clear,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [RIDX-1:0]      in_rega,
  input  logic [RIDX-1:0]      in_regb,
  input  logic                 in_use_a,
  input  logic                 in_use_b,
  input  logic [RIDX-1:0]      in_regd,
  input  logic                 in_wb_en,

  input  logic                 wb_valid,
  input  logic [RIDX-1:0]      wb_reg,
  input  logic [XLEN-1:0]      wb_data,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [XLEN-1:0]      out_rega_data,
  output logic [XLEN-1:0]      out_regb_data,
  output logic [RIDX-1:0]      out_regd,
  output logic                 out_wb_en,

  output logic                 stall_raw,
  output logic                 sb_err
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  rf       [NREG];
  logic [CNT_W-1:0] cnt      [NREG];
  logic [CNT_W-1:0] cnt_next [NREG];

  logic [XLEN-1:0] rega_data;
  logic [XLEN-1:0] regb_data;
  logic            hazard_a;
  logic            hazard_b;
  logic            hazard_waw;
  logic            issue;

  logic            cnt_inc;
  logic            cnt_dec_wb;
  logic            cnt_dec_fl;
  logic [CW1-1:0]  cnt_up;
  logic [CW1-1:0]  cnt_dn;

  // Operand read with write-through from the writeback port; register 0 is hardwired.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rega_data = rf[in_rega];
    regb_data = rf[in_regb];
    if (in_rega == '0)
      rega_data = '0;
    else if (wb_valid && (wb_reg == in_rega))
      rega_data = wb_data;
    if (in_regb == '0)
      regb_data = '0;
    else if (wb_valid && (wb_reg == in_regb))
      regb_data = wb_data;
  end

  // A last outstanding write landing this cycle is covered by write-through, not a stall.
  always_comb begin
    hazard_a = in_use_a && (cnt[in_rega] != '0) &&
               !((cnt[in_rega] == CNT_W'(1)) && wb_valid && (wb_reg == in_rega));
    hazard_b = in_use_b && (cnt[in_regb] != '0) &&
               !((cnt[in_regb] == CNT_W'(1)) && wb_valid && (wb_reg == in_regb));
    hazard_waw = in_wb_en && (cnt[in_regd] == CNT_MAX);
  end

  assign stall_raw = in_valid && (hazard_a || hazard_b || hazard_waw);
  assign in_ready  = !stall_raw && (!out_valid || out_ready) && !flush && !sb_clear && !reset;
  assign issue     = in_valid && in_ready;

  // Net counter change: +1 on issue, -1 per writeback and per squashed in-flight write.
  always_comb begin
    cnt_inc    = 1'b0;
    cnt_dec_wb = 1'b0;
    cnt_dec_fl = 1'b0;
    cnt_up     = '0;
    cnt_dn     = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_inc    = issue && in_wb_en && (r != 0) && (in_regd == RIDX'(r));
      cnt_dec_wb = wb_valid && (wb_reg == RIDX'(r));
      cnt_dec_fl = flush && out_valid && out_wb_en && (out_regd == RIDX'(r));
      cnt_up     = {1'b0, cnt[r]} + CW1'(cnt_inc);
      cnt_dn     = CW1'(cnt_dec_wb) + CW1'(cnt_dec_fl);
      cnt_next[r] = (cnt_up > cnt_dn) ? CNT_W'(cnt_up - cnt_dn) : '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset || sb_clear) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_next[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      sb_err <= 1'b0;
    else if (wb_valid && (cnt[wb_reg] == '0))
      sb_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: the register file must come out of reset all-zero, so this array is reset
    // explicitly; that keeps it in flops rather than a RAM macro.
    if (reset) begin
      for (int r = 0; r < NREG; r++)
        rf[r] <= '0;
    end else if (wb_valid && (wb_reg != '0)) begin
      rf[wb_reg] <= wb_data;
    end
  end

  // Output register: operands are frozen at issue and never refreshed while held.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_payload   <= '0;
      out_rega_data <= '0;
      out_regb_data <= '0;
      out_regd      <= '0;
      out_wb_en     <= 1'b0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_payload   <= in_payload;
      out_rega_data <= rega_data;
      out_regb_data <= regb_data;
      out_regd      <= in_regd;
      out_wb_en     <= in_wb_en;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_sb_stage.sv
// Self-checking bench for decode_sb_stage: a vector table for the stall/ready logic,
// hand-written multi-cycle sequences, and an output scoreboard fed at issue time.
module tb_decode_sb_stage;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int CNT_W     = 2;
  localparam int PAYLOAD_W = 32;
  localparam int RIDX      = 5;

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic                 sb_clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [RIDX-1:0]      in_rega;
  logic [RIDX-1:0]      in_regb;
  logic                 in_use_a;
  logic                 in_use_b;
  logic [RIDX-1:0]      in_regd;
  logic                 in_wb_en;
  logic                 wb_valid;
  logic [RIDX-1:0]      wb_reg;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [XLEN-1:0]      out_rega_data;
  logic [XLEN-1:0]      out_regb_data;
  logic [RIDX-1:0]      out_regd;
  logic                 out_wb_en;
  logic                 stall_raw;
  logic                 sb_err;

  decode_sb_stage #(
    .XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .sb_clear(sb_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_payload(in_payload),
    .in_rega(in_rega), .in_regb(in_regb), .in_use_a(in_use_a), .in_use_b(in_use_b),
    .in_regd(in_regd), .in_wb_en(in_wb_en),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_payload(out_payload),
    .out_rega_data(out_rega_data), .out_regb_data(out_regb_data),
    .out_regd(out_regd), .out_wb_en(out_wb_en),
    .stall_raw(stall_raw), .sb_err(sb_err)
  );

  typedef struct {
    logic            v;
    logic [RIDX-1:0] ra;
    logic            ua;
    logic [RIDX-1:0] rb;
    logic            ub;
    logic [RIDX-1:0] rd;
    logic            we;
    logic            wv;
    logic [RIDX-1:0] wr;
    logic [XLEN-1:0] wd;
    logic            ordy;
    logic            fl;
    logic            clr;
    logic            rst;
    logic            es;
    logic            er;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0]      pc;
    logic [PAYLOAD_W-1:0] payload;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [RIDX-1:0]      rd;
    logic                 we;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  logic [XLEN-1:0] model_rf [NREG];
  logic [XLEN-1:0] pc_cnt;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] held_pc;
  int              total;
  int              bad;
  vec_t            tbl [15];
  vec_t            t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic vec_t iv(input logic v, input logic [RIDX-1:0] ra, input logic ua,
                              input logic [RIDX-1:0] rb, input logic ub,
                              input logic [RIDX-1:0] rd, input logic we,
                              input logic es, input logic er);
    vec_t r;
    r = '{default: '0};
    r.v = v; r.ra = ra; r.ua = ua; r.rb = rb; r.ub = ub; r.rd = rd; r.we = we;
    r.es = es; r.er = er; r.ordy = 1'b1;
    return r;
  endfunction

  function automatic vec_t with_wb(input vec_t x, input logic [RIDX-1:0] r, input logic [XLEN-1:0] d);
    vec_t y;
    y = x; y.wv = 1'b1; y.wr = r; y.wd = d;
    return y;
  endfunction

  // Expected operand value: reg 0 is zero, a same-cycle writeback wins, else the model.
  function automatic logic [XLEN-1:0] ed(input vec_t x, input logic [RIDX-1:0] r);
    if (r == '0) return '0;
    if (x.wv && (x.wr == r)) return x.wd;
    return model_rf[r];
  endfunction

  task automatic apply(input vec_t x, input string name);
    exp_t e;
    pc_cnt     = pc_cnt + 32'd4;
    last_pc    = pc_cnt;
    in_valid   = x.v;
    in_pc      = pc_cnt;
    in_payload = pc_cnt ^ 32'hC0DE_0000;
    in_rega    = x.ra;
    in_use_a   = x.ua;
    in_regb    = x.rb;
    in_use_b   = x.ub;
    in_regd    = x.rd;
    in_wb_en   = x.we;
    wb_valid   = x.wv;
    wb_reg     = x.wr;
    wb_data    = x.wd;
    out_ready  = x.ordy;
    flush      = x.fl;
    sb_clear   = x.clr;
    reset      = x.rst;
    #1;
    check({name, "_stall"}, 64'(stall_raw), 64'(x.es));
    check({name, "_ready"}, 64'(in_ready), 64'(x.er));
    if (x.v && x.er) begin
      e.pc      = pc_cnt;
      e.payload = pc_cnt ^ 32'hC0DE_0000;
      e.a       = ed(x, x.ra);
      e.b       = ed(x, x.rb);
      e.rd      = x.rd;
      e.we      = x.we;
      exp_q.push_back(e);
    end
    if (x.rst) begin
      for (int i = 0; i < NREG; i++) model_rf[i] = '0;
    end else if (x.wv && (x.wr != '0)) begin
      model_rf[x.wr] = x.wd;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on each accepted output; a flush or reset discards the held entry.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (flush && out_valid) begin
      if (exp_q.size() != 0) mon_e = exp_q.pop_front();
      else begin
        total++; bad++;
        $display("FAIL sb_flush_empty: got held pc %0h want no held entry", out_pc);
      end
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got output pc %0h want none", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc",      64'(out_pc),        64'(mon_e.pc));
        check("sb_payload", 64'(out_payload),   64'(mon_e.payload));
        check("sb_a",       64'(out_rega_data), 64'(mon_e.a));
        check("sb_b",       64'(out_regb_data), 64'(mon_e.b));
        check("sb_regd",    64'(out_regd),      64'(mon_e.rd));
        check("sb_wb_en",   64'(out_wb_en),     64'(mon_e.we));
      end
    end
  end

  task automatic check_reset_state(input string name);
    check({name, "_out_valid"}, 64'(out_valid),     64'(0));
    check({name, "_out_pc"},    64'(out_pc),        64'(0));
    check({name, "_payload"},   64'(out_payload),   64'(0));
    check({name, "_a"},         64'(out_rega_data), 64'(0));
    check({name, "_b"},         64'(out_regb_data), 64'(0));
    check({name, "_regd"},      64'(out_regd),      64'(0));
    check({name, "_wb_en"},     64'(out_wb_en),     64'(0));
    check({name, "_sb_err"},    64'(sb_err),        64'(0));
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pc_cnt = 32'h0000_1000;
    for (int i = 0; i < NREG; i++) model_rf[i] = '0;

    t = iv(0, 0, 0, 0, 0, 0, 0, 0, 0); t.rst = 1'b1;
    apply(t, "rst0");
    apply(t, "rst1");
    check_reset_state("init");

    // RAW stall/bypass, WAW, use flags, in_valid gating; out_ready held high.
    tbl[0]  = iv(1, 0, 0, 0, 0, 5, 1, 0, 1);
    tbl[1]  = iv(1, 5, 1, 0, 0, 6, 1, 1, 0);
    tbl[2]  = with_wb(iv(1, 5, 1, 0, 0, 6, 1, 0, 1), 5, 32'hA5);
    tbl[3]  = iv(1, 6, 1, 5, 1, 7, 1, 1, 0);
    tbl[4]  = with_wb(iv(1, 5, 1, 0, 1, 7, 1, 0, 1), 6, 32'h66);
    tbl[5]  = with_wb(iv(1, 6, 1, 7, 1, 0, 1, 0, 1), 7, 32'h77);
    tbl[6]  = iv(1, 0, 0, 0, 0, 8, 1, 0, 1);
    tbl[7]  = iv(1, 0, 0, 0, 0, 8, 1, 0, 1);
    tbl[8]  = with_wb(iv(1, 8, 1, 0, 0, 0, 0, 1, 0), 8, 32'h88);
    tbl[9]  = iv(1, 8, 1, 0, 0, 0, 0, 1, 0);
    tbl[10] = with_wb(iv(1, 8, 1, 0, 0, 9, 1, 0, 1), 8, 32'h89);
    tbl[11] = iv(0, 9, 1, 0, 0, 0, 0, 0, 1);
    tbl[12] = iv(1, 9, 1, 0, 0, 0, 0, 1, 0);
    tbl[13] = iv(1, 5, 0, 9, 0, 0, 0, 0, 1);
    tbl[14] = with_wb(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), 9, 32'h99);
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("v%0d", i));
    check("tbl_sb_err", 64'(sb_err), 64'(0));

    // Backpressure: held output stays stable, next instruction lands one cycle after release.
    t = iv(1, 5, 1, 6, 1, 0, 0, 0, 1); t.ordy = 1'b0;
    apply(t, "bp_x");
    held_pc = last_pc;
    for (int i = 0; i < 3; i++) begin
      t = iv(1, 7, 1, 0, 0, 0, 0, 0, 0); t.ordy = 1'b0;
      apply(t, "bp_hold");
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_pc",    64'(out_pc),    64'(held_pc));
    end
    apply(iv(1, 7, 1, 0, 0, 0, 0, 0, 1), "bp_go");
    check("bp_go_valid", 64'(out_valid), 64'(1));
    check("bp_go_pc",    64'(out_pc),    64'(last_pc));
    apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), "idle0");
    check("drain_valid", 64'(out_valid), 64'(0));

    // Saturation at 3 pending writes to r7, then release by one writeback.
    for (int i = 0; i < 3; i++) apply(iv(1, 0, 0, 0, 0, 7, 1, 0, 1), "sat_n");
    apply(iv(1, 0, 0, 0, 0, 7, 1, 1, 0), "sat_full");
    apply(with_wb(iv(1, 0, 0, 0, 0, 7, 1, 1, 0), 7, 32'h70), "sat_wb");
    apply(iv(1, 0, 0, 0, 0, 7, 1, 0, 1), "sat_go");
    check("sat_sb_err", 64'(sb_err), 64'(0));

    // sb_clear wipes the pending count on r7 and blocks issue that cycle.
    t = iv(1, 7, 1, 0, 0, 0, 0, 1, 0); t.clr = 1'b1;
    apply(t, "clr");
    apply(iv(1, 7, 1, 0, 0, 0, 0, 0, 1), "after_clr");
    apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), "idle1");

    // Flush of a held write to r9 releases its pending count.
    t = iv(1, 0, 0, 0, 0, 9, 1, 0, 1); t.ordy = 1'b0;
    apply(t, "fl_iss");
    t = iv(0, 0, 0, 0, 0, 0, 0, 0, 0); t.ordy = 1'b0; t.fl = 1'b1;
    apply(t, "flush");
    check("flush_valid", 64'(out_valid), 64'(0));
    apply(iv(1, 9, 1, 0, 0, 0, 0, 0, 1), "after_fl");

    // Writeback with nothing pending, then register 0 behaviour.
    apply(with_wb(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), 3, 32'h3C), "err_wb");
    check("err_sb_err", 64'(sb_err), 64'(1));
    apply(with_wb(iv(1, 3, 1, 0, 1, 0, 1, 0, 1), 0, 32'hFFFF), "zero_iss");
    apply(iv(1, 0, 1, 0, 1, 0, 1, 0, 1), "zero_use");
    apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), "idle2");

    // Reset while a write to r10 is held and pending.
    t = iv(1, 0, 0, 0, 0, 10, 1, 0, 1); t.ordy = 1'b0;
    apply(t, "rs_iss");
    check("rs_held_valid", 64'(out_valid), 64'(1));
    t = iv(1, 10, 1, 0, 0, 0, 0, 1, 0); t.ordy = 1'b0; t.rst = 1'b1;
    apply(t, "rs");
    check_reset_state("mid_rst");
    apply(iv(1, 10, 1, 5, 1, 0, 0, 0, 1), "post_rs");
    apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), "idle3");
    apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), "idle4");

    check("sb_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_sb_stage.md
DECODE_SB_STAGE -- requirements
Module: decode_sb_stage

Interface
REQ-001 Parameter XLEN, default 32: register and PC data width.
REQ-002 Parameter NREG, default 32: architectural register count; RIDX = clog2(NREG).
REQ-003 Parameter CNT_W, default 2: width of each per-register scoreboard counter.
REQ-004 Parameter PAYLOAD_W, default 32: width of opaque decoded-control payload carried through unchanged.
REQ-005 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port flush, input, 1: squash the instruction held in the output register.
REQ-008 Port sb_clear, input, 1: clear all scoreboard counters (trap/IRET recovery).
REQ-009 Ports in_valid (in, 1) and in_ready (out, 1): upstream handshake; issue = in_valid && in_ready.
REQ-010 Ports in_pc (in, XLEN) and in_payload (in, PAYLOAD_W): carried through to the output register.
REQ-011 Ports in_rega and in_regb (in, RIDX each), with in_use_a and in_use_b (in, 1 each): source registers and their use flags.
REQ-012 Ports in_regd (in, RIDX) and in_wb_en (in, 1): destination register and write intent.
REQ-013 Ports wb_valid (in, 1), wb_reg (in, RIDX) and wb_data (in, XLEN): writeback port.
REQ-014 Ports out_valid (out, 1) and out_ready (in, 1): downstream handshake.
REQ-015 Ports out_pc, out_payload, out_rega_data, out_regb_data, out_regd and out_wb_en (out, widths as the matching inputs or XLEN): registered outputs.
REQ-016 Port stall_raw, out, 1: combinational; high when the current in_valid instruction is blocked by the scoreboard.
REQ-017 Port sb_err, out, 1: sticky flag; set by a writeback to a register whose counter is 0.

Function
REQ-018 Register file SHALL hold NREG x XLEN entries with 1 write port and 2 read ports.
REQ-019 Register 0 SHALL read as 0, ignore writes and never become pending.
REQ-020 A read of a register written in the same cycle SHALL return wb_data (write-through).
REQ-021 Each register r SHALL have an unsigned counter cnt[r] of CNT_W bits.
REQ-022 cnt[r] SHALL increment on issue with in_wb_en=1, in_regd=r, r!=0.
REQ-023 cnt[r] SHALL decrement on wb_valid with wb_reg=r.
REQ-024 If the increment and decrement for the same r occur in one cycle, cnt[r] SHALL be unchanged.
REQ-025 Source A hazard SHALL be in_use_a && cnt[in_rega]!=0, except when cnt[in_rega]==1 && wb_valid && wb_reg==in_rega.
REQ-026 Source B hazard SHALL follow the same rule as REQ-025, using in_use_b and in_regb.
REQ-027 WAW saturation hazard SHALL be in_wb_en && cnt[in_regd]==2^CNT_W-1 (no counter overflow).
REQ-028 stall_raw SHALL equal in_valid && (A hazard || B hazard || WAW hazard).
REQ-029 in_ready SHALL equal !stall_raw && (!out_valid || out_ready) && !flush && !sb_clear && !reset.
REQ-030 On issue, the output register SHALL capture in_pc, in_payload, in_regd, in_wb_en and both read data values (including write-through); out_valid SHALL be 1 the next cycle (latency 1).
REQ-031 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-032 If out_valid && out_ready && no issue, out_valid SHALL go to 0 the next cycle.
REQ-033 On flush, out_valid SHALL be 0 the next cycle; if the squashed entry had out_valid && out_wb_en, cnt[out_regd] SHALL also decrement, combined with any writeback per REQ-024.
REQ-034 On sb_clear, all counters SHALL be 0 the next cycle, overriding every increment and decrement.
REQ-035 A writeback to a register with cnt==0 SHALL leave the counter at 0, set sb_err, and still write the data.
REQ-036 Operand data SHALL be sampled only at issue; no later forwarding into the held output.

Reset
REQ-037 When reset=1 at a clock edge, the following SHALL be 0 next cycle: out_valid, out_pc, out_payload, out_rega_data, out_regb_data, out_regd, out_wb_en, every cnt[r], sb_err and every register-file entry.
REQ-038 Reset SHALL override flush, sb_clear, issue and writeback in the same cycle.
REQ-039 A reset mid-stall SHALL drop the held instruction without a decrement.

Verification
REQ-040 RAW stall: issue rd=5 (wb_en); next cycle instruction uses regA=5 -> stall_raw=1, in_ready=0. Then wb_valid reg 5 data 0xA5 -> issue in that same cycle, out_rega_data=0xA5.
REQ-041 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 -> next instruction appears after 1 cycle.
REQ-042 Saturation (CNT_W=2): 3 issues to rd=7 with no writeback -> cnt[7]=3; the 4th issue to rd=7 stalls; one wb to 7 -> the 4th issues.
REQ-043 Flush: issue rd=9; flush while held -> out_valid=0 and cnt[9]=0; a following use of reg 9 is not stalled.
REQ-044 Error and zero register: wb to reg 3 with cnt=0 -> sb_err=1 and reg 3 is written; issue with rd=0 -> cnt[0] stays 0 and a read of reg 0 returns 0.
REQ-045 Reset mid-operation: pending counters and out_valid=1, assert reset -> every reset value per REQ-037 next cycle.
